wb_select_unit: RTL and testbench
=================================

WB_SELECT_UNIT -- requirements
Module: wb_select_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of write-back data.
REQ-002 Parameter NSRC, default 6, number of external data sources.
REQ-003 Parameter SEL_W, default 4, selector width; SHALL satisfy 2**SEL_W >= NSRC+3.
REQ-004 Parameter TIMEOUT, default 64, maximum WAIT cycles before abort.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 src_bus  in  NSRC*DATA_W  packed sources; source i in bits [i*DATA_W +: DATA_W].
REQ-008 src_rdy  in  NSRC  per-source data-ready flags (e.g. HI/LO low while mult/div busy).
REQ-009 req_valid  in  1  write-back request.
REQ-010 req_ready  out  1  unit can accept a request.
REQ-011 req_sel  in  SEL_W  source select.
REQ-012 req_size  in  2  00 word, 01 half, 10 byte, 11 word.
REQ-013 req_sign  in  1  1 = sign-extend half/byte, 0 = zero-extend.
REQ-014 wr_valid  out  1  write data valid for the register file.
REQ-015 wr_ready  in  1  register file accepts wr_data.
REQ-016 wr_data  out  DATA_W  selected, size-adjusted data.
REQ-017 err  out  1  one-cycle pulse: illegal select or timeout.

Function
REQ-018 Select decode: sel < NSRC -> src_bus slice sel; sel = NSRC -> constant 227; NSRC+1 -> 0; NSRC+2 -> 1; larger values illegal.
REQ-019 Constant selects are always ready; an external select is ready when src_rdy[sel] = 1.
REQ-020 FSM states: IDLE, WAIT, OUT; req_ready = 1 only in IDLE.
REQ-021 IDLE, handshake (req_valid & req_ready): latch sel/size/sign; illegal sel -> err pulse next cycle, stay IDLE; source ready -> capture data, go OUT; otherwise go WAIT with wait counter cleared.
REQ-022 WAIT: each cycle sample the source; ready -> capture, go OUT; counter reaching TIMEOUT-1 while not ready -> err pulse, go IDLE, no write issued.
REQ-023 Latency: ready source gives wr_valid = 1 in the cycle after the request handshake.
REQ-024 OUT: wr_valid = 1 and wr_data held stable until wr_ready = 1; on wr_ready go IDLE next cycle.
REQ-025 Source values are sampled only at capture; later source changes do not affect wr_data.
REQ-026 Size: half takes bits [15:0], byte takes bits [7:0], extended to DATA_W per req_sign; word and 11 pass all DATA_W bits.
REQ-027 Size/sign rules apply to constants identically.
REQ-028 req_valid in WAIT or OUT is ignored (not accepted, not queued).

Reset
REQ-029 Reset SHALL force IDLE; wr_valid = 0, wr_data = 0, err = 0, wait counter = 0, latched fields = 0.
REQ-030 Reset mid-WAIT or mid-OUT SHALL abort silently: no err and no wr_valid after reset.
REQ-031 Reset has priority over every simultaneous event.

Structure
REQ-032 Shared package wb_pkg SHALL hold the FSM state enum, size encodings (SZ_WORD/SZ_HALF/SZ_BYTE) and constants EXC_VEC = 227, ZERO = 0, ONE = 1.
REQ-033 Size/sign extension SHALL be one combinational sub-module, wb_extend, instantiated once on the capture path.
REQ-034 Wait counter width SHALL be $clog2(TIMEOUT)+1 bits.

Verification
REQ-035 src0 = 32'h0000_1234, rdy = all 1, sel 0, word -> wr_valid at cycle +1, wr_data 32'h0000_1234; wr_ready held 0 for 3 cycles -> wr_data stable throughout.
REQ-036 sel = NSRC (6), word -> wr_data = 227; sel 7 -> 0; sel 8 -> 1; sel 9 -> err pulse, no wr_valid.
REQ-037 src1 = 32'h0000_80F0, sel 1, half, sign 1 -> 32'hFFFF_80F0; byte, sign 0 -> 32'h0000_00F0; byte, sign 1 -> 32'hFFFF_FFF0.
REQ-038 sel 2, src_rdy[2] = 0 for 5 cycles then 1 with src2 = 32'hDEAD_BEEF -> WAIT for 5 cycles, then wr_valid with 32'hDEAD_BEEF.
REQ-039 sel 3, src_rdy[3] held 0, TIMEOUT = 64 -> err pulse after 64 WAIT cycles, return to IDLE, req_ready = 1.
REQ-040 reset asserted during WAIT and during OUT -> next cycle IDLE, wr_valid = 0, err = 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM states, size encodings and constant sources for wb_select_unit
package wb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam int EXC_VEC = 227;
    localparam int ZERO    = 0;
    localparam int ONE     = 1;
endpackage

// File: rtl/wb_extend.sv
// wb_extend: half/byte zero- or sign-extension; din raw data, size/sign controls, dout adjusted data
module wb_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic [DATA_W-1:0] dout
);
    always_comb dout = size == SZ_HALF ? {{(DATA_W-16){sign & din[15]}}, din[15:0]} :
                       size == SZ_BYTE ? {{(DATA_W-8){sign & din[7]}}, din[7:0]} : din;
endmodule

// File: rtl/wb_select_unit.sv
// wb_select_unit: selects, waits for and size-adjusts write-back data; req_* request side, wr_* register-file side, err abort pulse
module wb_select_unit
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NSRC    = 6,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NSRC*DATA_W-1:0] src_bus,
    input  logic [NSRC-1:0]        src_rdy,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SEL_W-1:0]       req_sel,
    input  logic [1:0]             req_size,
    input  logic                   req_sign,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   err
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int NT = 2 ** SEL_W;
    state_t state, nxt;
    logic [SEL_W-1:0] sel_q, cur_sel;
    logic [1:0] size_q, cur_size;
    logic sign_q, cur_sign, legal, rdy, cap, err_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] tab [NT];
    logic [NT-1:0] rdy_v;
    logic [DATA_W-1:0] ext;
    // full 2**SEL_W table: external sources first, then the constants (always ready)
    for (genvar i = 0; i < NT; i++) begin : g
        if (i < NSRC) begin : s
            assign tab[i]   = src_bus[i*DATA_W +: DATA_W];
            assign rdy_v[i] = src_rdy[i];
        end else begin : c
            assign tab[i]   = i == NSRC ? DATA_W'(EXC_VEC) : i == NSRC + 1 ? DATA_W'(ZERO) : DATA_W'(ONE);
            assign rdy_v[i] = 1'b1;
        end
    end
    // in IDLE the live request drives the capture path so a ready source captures on the handshake
    always_comb begin
        cur_sel  = state == IDLE ? req_sel : sel_q;
        cur_size = state == IDLE ? req_size : size_q;
        cur_sign = state == IDLE ? req_sign : sign_q;
        legal    = 32'(cur_sel) < 32'(NSRC + 3);
        rdy      = rdy_v[cur_sel];
    end
    wb_extend #(.DATA_W(DATA_W)) u_ext (
        .din  (tab[cur_sel]),
        .size (cur_size),
        .sign (cur_sign),
        .dout (ext)
    );
    always_comb begin
        nxt   = state;
        cap   = 1'b0;
        err_n = 1'b0;
        cnt_n = cnt;
        case (state)
            IDLE: if (req_valid) begin
                if (!legal) err_n = 1'b1;
                else if (rdy) begin
                    cap = 1'b1;
                    nxt = OUT;
                end else begin
                    nxt   = WAIT;
                    cnt_n = '0;
                end
            end
            WAIT: if (rdy) begin
                cap = 1'b1;
                nxt = OUT;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                err_n = 1'b1;
                nxt   = IDLE;
            end else cnt_n = cnt + 1'b1;
            OUT: nxt = wr_ready ? IDLE : OUT;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sel_q   <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            cnt     <= '0;
            wr_data <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            err   <= err_n;
            if (state == IDLE && req_valid) {sel_q, size_q, sign_q} <= {req_sel, req_size, req_sign};
            if (cap) wr_data <= ext;
        end
    end
    assign req_ready = state == IDLE;
    assign wr_valid  = state == OUT;
endmodule

// File: tb/tb_wb_select_unit.sv
// tb_wb_select_unit: randomized scoreboard bench for wb_select_unit
module tb_wb_select_unit;
    localparam int DW = 32, NS = 6, SW = 4, TO = 64;
    logic clk = 1'b0, reset = 1'b1;
    logic [NS*DW-1:0] src_bus = '0;
    logic [NS-1:0] src_rdy = '0;
    logic req_valid = 1'b0, req_ready, req_sign = 1'b0, wr_valid, wr_ready = 1'b0, err;
    logic [SW-1:0] req_sel = '0;
    logic [1:0] req_size = '0;
    logic [DW-1:0] wr_data;
    int checks = 0, errors = 0, rdy_mode = 0;
    typedef struct packed {logic e; logic [31:0] d;} exp_t;
    exp_t q[$];

    wb_select_unit #(.DATA_W(DW), .NSRC(NS), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .src_bus(src_bus), .src_rdy(src_rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_size(req_size), .req_sign(req_sign), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ref_val(input int sel, input logic [31:0] v, input int sz, input bit sg);
        logic [31:0] b, m;
        b = sel == NS ? 32'd227 : sel == NS + 1 ? 32'd0 : sel == NS + 2 ? 32'd1 : v;
        if (sz != 1 && sz != 2) return b;
        m = sz == 1 ? 32'd65536 : 32'd256;
        b = b % m;
        if (sg && b >= m / 2) b = b - m;
        return b;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_src;
        for (int i = 0; i < NS; i++) src_bus[i*DW +: DW] = $urandom;
        src_rdy = NS'($urandom);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        do begin
            step;
            rnd_src;
            n++;
        end while (!req_ready && n < 300);
        chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input int sel, input int sz, input bit sg, input int k, input logic [31:0] v0);
        wait_idle;
        req_valid = 1'b1;
        req_sel   = SW'(sel);
        req_size  = 2'(sz);
        req_sign  = sg;
        if (sel < NS) begin
            src_bus[sel*DW +: DW] = v0;
            src_rdy[sel] = k == 0;
        end
        if (sel > NS + 2) q.push_back('{1'b1, 32'h0});
        else if (sel >= NS || k == 0) q.push_back('{1'b0, ref_val(sel, v0, sz, sg)});
        step;
        req_valid = 1'b0;
        if (sel > NS + 2) begin
            chk("illegal_no_write", 32'(wr_valid), 32'd0);
            chk("illegal_idle", 32'(req_ready), 32'd1);
        end else if (sel >= NS || k == 0) chk("latency", 32'(wr_valid), 32'd1);
        else for (int i = 0; i < TO; i++) begin
            rnd_src;
            if (i == k) begin
                src_bus[sel*DW +: DW] = v0;
                src_rdy[sel] = 1'b1;
                q.push_back('{1'b0, ref_val(sel, v0, sz, sg)});
            end else src_rdy[sel] = 1'b0;
            if (i == TO - 1 && k >= TO) q.push_back('{1'b1, 32'h0});
            step;
            if (i == k) begin
                chk("wait_capture", 32'(wr_valid), 32'd1);
                break;
            end
            if (i == TO - 1) begin
                chk("timeout_idle", 32'(req_ready), 32'd1);
                chk("timeout_no_write", 32'(wr_valid), 32'd0);
            end
        end
    endtask

    task automatic post_reset(input string tag);
        chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        step;
        chk({tag, "_err_after"}, 32'(err), 32'd0);
        chk({tag, "_wr_valid_after"}, 32'(wr_valid), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        wr_ready = rdy_mode != 0 ? 1'b0 : ($urandom % 4 != 0);
    end

    initial begin : monitor
        logic hold;
        logic [31:0] hd;
        exp_t e;
        hold = 1'b0;
        hd = '0;
        forever begin
            @(negedge clk);
            if (reset) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold_valid", 32'(wr_valid), 32'd1);
                    chk("hold_data", wr_data, hd);
                end
                if (err || (wr_valid && wr_ready)) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output err=%b wr_data=%h required=none", err, wr_data);
                    end else begin
                        e = q.pop_front();
                        chk("out_kind_err", 32'(err), 32'(e.e));
                        if (!e.e) chk("wr_data", wr_data, e.d);
                    end
                end
                hold = wr_valid && !wr_ready;
                hd = wr_data;
            end
        end
    end

    initial begin
        int n, r, k;
        repeat (3) step;
        chk("reset_wr_valid", 32'(wr_valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_wr_data", wr_data, 32'd0);
        reset = 1'b0;
        step;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rdy_mode = 1;
        issue(0, 0, 1'b0, 0, 32'h0000_1234);
        repeat (3) step;
        rdy_mode = 0;
        issue(NS, 0, 1'b0, 0, 32'h5555_5555);
        issue(NS + 1, 0, 1'b0, 0, 32'h5555_5555);
        issue(NS + 2, 0, 1'b0, 0, 32'h5555_5555);
        issue(NS + 3, 0, 1'b0, 0, 32'h5555_5555);
        issue(NS, 2, 1'b1, 0, 32'h0);
        issue(1, 1, 1'b1, 0, 32'h0000_80F0);
        issue(1, 2, 1'b0, 0, 32'h0000_80F0);
        issue(1, 2, 1'b1, 0, 32'h0000_80F0);
        issue(2, 0, 1'b0, 5, 32'hDEAD_BEEF);
        issue(3, 0, 1'b0, 1000, 32'h0);
        wait_idle;
        req_valid = 1'b1;
        req_sel = 4'd3;
        req_size = 2'd0;
        src_rdy[3] = 1'b0;
        step;
        req_valid = 1'b0;
        repeat (3) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        post_reset("rst_wait");
        wait_idle;
        rdy_mode = 1;
        req_valid = 1'b1;
        req_sel = 4'd0;
        src_rdy = '1;
        step;
        req_valid = 1'b0;
        chk("pre_reset_out", 32'(wr_valid), 32'd1);
        reset = 1'b1;
        step;
        reset = 1'b0;
        rdy_mode = 0;
        post_reset("rst_out");
        for (int t = 0; t < 150; t++) begin
            r = int'($urandom % 20);
            k = r < 10 ? 0 : r < 19 ? r - 9 : TO + int'($urandom % 4);
            issue(int'($urandom % 16), int'($urandom % 4), 1'($urandom), k, $urandom);
        end
        n = 0;
        while (q.size() != 0 && n < 500) begin
            step;
            n++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
